operand_stack_ctrl: RTL

OPERAND_STACK_CTRL -- requirements
Module: operand_stack_ctrl

---
 rtl/operand_stack_ctrl_pkg.sv | 19 +
 rtl/operand_stack_ctrl_ram.sv | 25 ++
 rtl/operand_stack_ctrl.sv | 121 ++++++++++++
 3 files changed

// File: rtl/operand_stack_ctrl_pkg.sv
// Shared constants for the operand stack controller: command codes, ALU opcodes, FSM states.
package operand_stack_ctrl_pkg;

  localparam logic [1:0] CMD_PUSH  = 2'd0;
  localparam logic [1:0] CMD_POP   = 2'd1;
  localparam logic [1:0] CMD_EXEC  = 2'd2;
  localparam logic [1:0] CMD_CLEAR = 2'd3;

  localparam logic [3:0] ALU_NOP = 4'd0;
  localparam logic [3:0] ALU_ADD = 4'd3;
  localparam logic [3:0] ALU_OR  = 4'd4;
  localparam logic [3:0] ALU_SUB = 4'd5;
  localparam logic [3:0] ALU_SLT = 4'd6;
  localparam logic [3:0] ALU_NOR = 4'd7;
  localparam logic [3:0] ALU_AND = 4'd8;

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_EXEC, ST_WB} state_t;

endpackage

// File: rtl/operand_stack_ctrl_ram.sv
// Stack storage: DEPTH x WIDTH register file, one write port, two asynchronous read ports.
module opstack_ram #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr_a,
  input  logic [AW-1:0]    raddr_b,
  output logic [WIDTH-1:0] rdata_a,
  output logic [WIDTH-1:0] rdata_b
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/operand_stack_ctrl.sv
// Operand stack feeding an external combinational ALU (IDLE/LOAD/EXEC/WB).
// Define OPSTACK_STICKY_ERR_EN to make err_over/err_under hold until CLEAR or reset.
module operand_stack_ctrl
  import operand_stack_ctrl_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_code,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [3:0]       cmd_alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic [WIDTH-1:0] top,
  output logic [CW-1:0]    count,
  output logic             zero_flag,
  output logic             err_over,
  output logic             err_under
);

  state_t           state, state_nx;
  logic [3:0]       op_reg;
  logic [WIDTH-1:0] a_reg, b_reg, res_reg;
  logic             zero_reg;
  logic [AW-1:0]    sp;
  logic [WIDTH-1:0] rd_a, rd_b, wdata;
  logic             accept, full, push_ok, pop_ok, exec_ok, clr, over_hit, under_hit, we;

  // sp is the low bits of count, so it wraps modulo DEPTH on its own
  assign sp        = count[AW-1:0];
  assign cmd_ready = (state == ST_IDLE);
  assign accept    = cmd_valid & cmd_ready;
  assign full      = (count == CW'(DEPTH));
  assign push_ok   = accept & (cmd_code == CMD_PUSH) & ~full;
  assign over_hit  = accept & (cmd_code == CMD_PUSH) & full;
  assign pop_ok    = accept & (cmd_code == CMD_POP) & (count != '0);
  assign exec_ok   = accept & (cmd_code == CMD_EXEC) & (count >= CW'(2));
  assign under_hit = accept & (((cmd_code == CMD_POP) & (count == '0)) |
                               ((cmd_code == CMD_EXEC) & (count < CW'(2))));
  assign clr       = accept & (cmd_code == CMD_CLEAR);

  // WB writes at the sp left behind by LOAD's count-2
  assign we    = push_ok | (state == ST_WB);
  assign wdata = (state == ST_WB) ? res_reg : cmd_data;

  opstack_ram #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_ram (
    .clk     (clk),
    .we      (we),
    .waddr   (sp),
    .wdata   (wdata),
    .raddr_a (sp - AW'(2)),
    .raddr_b (sp - AW'(1)),
    .rdata_a (rd_a),
    .rdata_b (rd_b)
  );

  assign top    = (count == '0) ? '0 : rd_b;
  assign alu_a  = a_reg;
  assign alu_b  = b_reg;
  assign alu_op = (state == ST_EXEC) ? op_reg : ALU_NOP;

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (exec_ok) state_nx = ST_LOAD;
      ST_LOAD: state_nx = ST_EXEC;
      ST_EXEC: state_nx = ST_WB;
      ST_WB:   state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      count     <= '0;
      op_reg    <= ALU_NOP;
      a_reg     <= '0;
      b_reg     <= '0;
      res_reg   <= '0;
      zero_reg  <= 1'b0;
      zero_flag <= 1'b0;
      err_over  <= 1'b0;
      err_under <= 1'b0;
    end else begin
      state <= state_nx;
      if (clr)                            count <= '0;
      else if (push_ok || state == ST_WB) count <= count + CW'(1);
      else if (pop_ok)                    count <= count - CW'(1);
      else if (state == ST_LOAD)          count <= count - CW'(2);
      if (exec_ok) op_reg <= cmd_alu_op;
      if (state == ST_LOAD) begin
        a_reg <= rd_a;
        b_reg <= rd_b;
      end
      if (state == ST_EXEC) begin
        res_reg  <= alu_result;
        zero_reg <= alu_zero;
      end
      if (clr)                  zero_flag <= 1'b0;
      else if (state == ST_WB)  zero_flag <= zero_reg;
`ifdef OPSTACK_STICKY_ERR_EN
      err_over  <= (err_over | over_hit) & ~clr;
      err_under <= (err_under | under_hit) & ~clr;
`else
      err_over  <= over_hit;
      err_under <= under_hit;
`endif
    end
  end

endmodule
